// File: rtl/afifo_wr_arb_if.sv
// rtl/afifo_wr_arb_if.sv - write-side bundle between requesters, arbiter and FIFO write port
interface afifo_wr_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int CNT_WIDTH  = 16
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          wfull;
  logic                          winc;
  logic [DATA_WIDTH-1:0]         wdata;
  logic                          full_evt;
  logic [CNT_WIDTH-1:0]          wr_cnt;
  logic [CNT_WIDTH-1:0]          stall_cnt;

  // environment side: requesters plus the FIFO full flag
  modport master (
    output req, req_data, wfull,
    input  gnt, winc, wdata, full_evt, wr_cnt, stall_cnt
  );

  // arbiter side
  modport slave (
    input  req, req_data, wfull,
    output gnt, winc, wdata, full_evt, wr_cnt, stall_cnt
  );
endinterface

// File: rtl/afifo_wr_arb.sv
// rtl/afifo_wr_arb.sv - round-robin write arbiter feeding an async FIFO write port
module afifo_wr_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic          wclk,
  input  logic          wrst,
  afifo_wr_arb_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t                  r_state, w_state_nxt;
  logic [NUM_REQ-1:0]      r_gnt;
  logic [NUM_REQ-1:0]      w_elig;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [IDX_W-1:0]        r_last;
  logic [IDX_W-1:0]        w_win;
  logic                    w_found;
  logic                    w_load;
  logic                    w_accept;
  logic                    w_stall;
  logic                    r_winc;
  logic                    r_full_evt;
  logic                    r_stalled;
  logic [CNT_WIDTH-1:0]    r_wr_cnt;
  logic [CNT_WIDTH-1:0]    r_stall_cnt;

  // a requester granted last cycle is masked so a held level req is not re-granted back to back
  assign w_elig   = bus.req & ~r_gnt;
  assign w_accept = r_winc & ~bus.wfull;
  assign w_stall  = r_winc & bus.wfull;

  // round-robin search starting one past the last loaded requester
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] cand;
    idx     = 0;
    cand    = '0;
    w_found = 1'b0;
    w_win   = r_last;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx  = (int'(r_last) + k) % NUM_REQ;
      cand = IDX_W'(idx);
      if (!w_found && w_elig[cand]) begin
        w_found = 1'b1;
        w_win   = cand;
      end
    end
  end

  // next state: load from IDLE, or in HOLD only on the edge that retires the pending word
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_load      = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!bus.wfull) begin
          if (w_found) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // state register; winc mirrors HOLD so it comes straight off a flop
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_state <= IDLE;
      r_winc  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_winc  <= (w_state_nxt == HOLD);
    end
  end

  // capture the winner's word, pulse its grant, remember it for the next search
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_wdata <= '0;
      r_gnt   <= '0;
      r_last  <= IDX_W'(NUM_REQ - 1);
    end else begin
      r_gnt <= '0;
      if (w_load) begin
        r_wdata <= bus.req_data[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
        r_gnt   <= NUM_REQ'(1) << w_win;
        r_last  <= w_win;
      end
    end
  end

  // statistics: wrapping write count, saturating stall count, one full event per pending word
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_wr_cnt    <= '0;
      r_stall_cnt <= '0;
      r_full_evt  <= 1'b0;
      r_stalled   <= 1'b0;
    end else begin
      r_full_evt <= w_stall & ~r_stalled;
      if (w_accept) begin
        r_wr_cnt  <= r_wr_cnt + CNT_WIDTH'(1);
        r_stalled <= 1'b0;
      end else if (w_stall) begin
        r_stalled <= 1'b1;
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.winc      = r_winc;
  assign bus.wdata     = r_wdata;
  assign bus.full_evt  = r_full_evt;
  assign bus.wr_cnt    = r_wr_cnt;
  assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: doc/afifo_wr_arb.md
AFIFO_WR_ARB -- requirements
Module: afifo_wr_arb

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- DATA_WIDTH, 32, width of the FIFO write word.
- NUM_REQ, 4, number of requesters; legal range 2..8.
- CNT_WIDTH, 16, width of the statistics counters.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- wclk, in, 1, write-domain clock; all logic is on the rising edge.
- wrst, in, 1, reset; asynchronous, active-high.
- req, in, NUM_REQ, per-requester write request; level signal.
- req_data, in, NUM_REQ*DATA_WIDTH, requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt, out, NUM_REQ, one-hot load acknowledge; single-cycle pulse.
- wfull, in, 1, FIFO full flag from the write domain.
- winc, out, 1, FIFO write strobe.
- wdata, out, DATA_WIDTH, FIFO write data.
- full_evt, out, 1, single-cycle pulse when a pending write first meets wfull.
- wr_cnt, out, CNT_WIDTH, count of accepted writes.
- stall_cnt, out, CNT_WIDTH, count of cycles with winc=1 and wfull=1.

REQ-003 Clock and reset SHALL be named wclk and wrst; one clock only, reset asynchronous and active-high.

REQ-004 All outputs SHALL be driven directly from flops.

Function
REQ-005 A FIFO write SHALL be accepted at a wclk edge exactly when winc=1 and wfull=0 at that edge.

REQ-006 The block SHALL use a two-state FSM: IDLE (winc=0) and HOLD (winc=1, wdata holds the pending word).

REQ-007 A requester i is eligible when req[i]=1 and gnt[i]=0 in the current cycle; the gnt mask prevents re-grant before the requester drops req.

REQ-008 In IDLE, when any requester is eligible, the FSM SHALL load the winner's data into wdata, pulse gnt[winner] for the next cycle, and go to HOLD.

REQ-009 In HOLD with wfull=0 (write accepted) and an eligible requester present, the FSM SHALL load the next winner in the same edge and stay in HOLD, giving one write per cycle sustained.

REQ-010 In HOLD with wfull=0 and no eligible requester, the FSM SHALL go to IDLE and clear winc.

REQ-011 In HOLD with wfull=1, the block SHALL keep winc, wdata and state unchanged, load nothing, and leave gnt at 0.

REQ-012 Arbitration SHALL be round-robin: the search starts at (last_loaded+1) mod NUM_REQ and the first eligible index wins; last_loaded updates only on a load.

REQ-013 Load-to-acceptance latency SHALL be 1 cycle minimum: winc rises in the cycle after the arbitration edge.

REQ-014 gnt SHALL be high during the cycle in which wdata first shows that requester's word.

REQ-015 wr_cnt SHALL increment by 1 on each accepted write and wrap modulo 2^CNT_WIDTH.

REQ-016 stall_cnt SHALL increment on each edge with winc=1 and wfull=1, and saturate at all-ones.

REQ-017 full_evt SHALL pulse for one cycle after the first stall edge of each HOLD episode; a continuous stall SHALL produce no further pulses.

REQ-018 A wfull deassertion followed by reassertion within the same pending word SHALL produce no second full_evt if no write was accepted in between.

REQ-019 Changes on req_data of a non-winning requester SHALL have no effect.

REQ-020 Changes on req_data of the winner after its load edge SHALL have no effect on wdata.

Reset
REQ-021 While wrst=1, the block SHALL hold state=IDLE, winc=0, wdata=0, gnt=0, full_evt=0, wr_cnt=0, stall_cnt=0, last_loaded=NUM_REQ-1 (requester 0 has first priority).

REQ-022 Reset asserted mid-operation SHALL discard the pending word with no write and no gnt; outputs SHALL clear immediately, without waiting for wclk.

REQ-023 After wrst deasserts, the first load SHALL occur no earlier than the first wclk edge.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Single requester: req[2]=1 with data 0xA5A5_0001, wfull=0 -> gnt=4'b0100 for 1 cycle; winc=1 with wdata=0xA5A5_0001 for 1 cycle; wr_cnt=1.
- All four requesting continuously, wfull=0, 8 cycles -> grant order 0,1,2,3,0,1,2,3; winc high every cycle after the first; wr_cnt=8.
- Pending write with wfull=1 for 5 cycles, then 0 -> winc and wdata held; one full_evt pulse; stall_cnt=5; one accept; wr_cnt=1.
- Only req[1] held high continuously -> gnt[1] pulses every other cycle, never on consecutive cycles.
- wrst pulsed while in HOLD with wfull=1 -> winc=0 and counters 0 asynchronously; no accept of the old word; next grant goes to requester 0.
- stall_cnt preloaded near all-ones by a long full condition -> holds at all-ones; wr_cnt wraps from all-ones to 0 on the next accept.
